// File: rtl/hall_counter_pkg.sv
// Shared register offsets, bit positions and period-state encoding for the
// multi-channel hall speed counter.
package hall_counter_pkg;

    localparam logic [1:0] REG_COUNT  = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_CLR    = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned ST_STALL = 0;
    localparam int unsigned ST_OVF   = 1;
    localparam int unsigned ST_VALID = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } period_state_e;

endpackage

// File: rtl/hall_channel.sv
// One hall input: synchroniser, debounce, rising-edge counter, period
// measurement FSM and per-channel CTRL/STATUS bits with register readback.
module hall_channel
    import hall_counter_pkg::*;
#(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned PERIOD_W     = 24,
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hall_in,
    input  logic        ctrl_we,
    input  logic        status_we,
    input  logic [2:0]  wr_bits,
    input  logic [1:0]  reg_sel,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DW-1:0]       DEB_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [PERIOD_W-1:0] P_SAT    = '1;
    localparam logic [PERIOD_W-1:0] P_PRE    = P_SAT - 1'b1;
    localparam logic [PERIOD_W-1:0] P_ONE    = PERIOD_W'(1);

    logic [1:0]          sync;
    logic                filt;
    logic [DW-1:0]       deb_cnt;
    logic                edge_q;
    logic [CNT_W-1:0]    count;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] pcnt;
    period_state_e       state;
    logic                en;
    logic                irq_en;
    logic                stall;
    logic                ovf;
    logic                valid;
    logic                clr;

    assign clr = ctrl_we & wr_bits[CTRL_CLR];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync    <= '0;
            filt    <= 1'b0;
            deb_cnt <= '0;
            edge_q  <= 1'b0;
            count   <= '0;
            period  <= '0;
            pcnt    <= '0;
            state   <= IDLE;
            en      <= 1'b0;
            irq_en  <= 1'b0;
            stall   <= 1'b0;
            ovf     <= 1'b0;
            valid   <= 1'b0;
        end else begin
            sync   <= {sync[0], hall_in};
            edge_q <= 1'b0;
            if (sync[1] != filt) begin
                if (deb_cnt == DEB_LAST) begin
                    filt    <= sync[1];
                    deb_cnt <= '0;
                    edge_q  <= sync[1];
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end

            if (ctrl_we) begin
                en     <= wr_bits[CTRL_EN];
                irq_en <= wr_bits[CTRL_IRQ_EN];
            end

            // W1C first so that any set later in this block takes priority
            if (status_we) begin
                if (wr_bits[ST_STALL]) stall <= 1'b0;
                if (wr_bits[ST_OVF])   ovf   <= 1'b0;
                if (wr_bits[ST_VALID]) valid <= 1'b0;
            end

            if (clr) begin
                count  <= '0;
                period <= '0;
                pcnt   <= '0;
                valid  <= 1'b0;
                state  <= IDLE;
            end else if (!en) begin
                pcnt  <= '0;
                state <= IDLE;
            end else begin
                if (edge_q) begin
                    count <= count + 1'b1;
                    if (&count) ovf <= 1'b1;
                end
                unique case (state)
                    IDLE: begin
                        if (edge_q) begin
                            state <= RUN;
                            pcnt  <= P_ONE;
                            valid <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (edge_q) begin
                            period <= pcnt;
                            pcnt   <= P_ONE;
                            valid  <= 1'b1;
                            stall  <= 1'b0;
                        end else if (pcnt != P_SAT) begin
                            pcnt <= pcnt + 1'b1;
                            if (pcnt == P_PRE) stall <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            REG_COUNT:  rdata[CNT_W-1:0]    = count;
            REG_PERIOD: rdata[PERIOD_W-1:0] = period;
            REG_CTRL: begin
                rdata[CTRL_EN]     = en;
                rdata[CTRL_IRQ_EN] = irq_en;
            end
            REG_STATUS: begin
                rdata[ST_STALL] = stall;
                rdata[ST_OVF]   = ovf;
                rdata[ST_VALID] = valid;
            end
        endcase
    end

    assign irq = irq_en & (stall | ovf | valid);

endmodule

// File: rtl/hall_speed_counter_mc.sv
// Multi-channel hall speed counter: Avalon-MM decode, registered read mux and
// combined interrupt over NUM_CH hall_channel instances.
module hall_speed_counter_mc
    import hall_counter_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned PERIOD_W     = 24,
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_CH-1:0]            hall_in,
    input  logic [$clog2(NUM_CH)+1:0]    avs_address,
    input  logic                         avs_read,
    input  logic                         avs_write,
    input  logic [31:0]                  avs_writedata,
    output logic [31:0]                  avs_readdata,
    output logic                         irq
);

    logic [1:0]        reg_sel;
    int unsigned       ch_idx;
    logic [NUM_CH-1:0] ctrl_we;
    logic [NUM_CH-1:0] status_we;
    logic [NUM_CH-1:0] irq_ch;
    logic [31:0]       rdata_ch [NUM_CH];
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign reg_sel      = avs_address[1:0];
    assign ch_idx       = 32'(avs_address >> 2);
    assign unused_wdata = ^avs_writedata[31:3];

    // Only implemented channel indices ever match, so out-of-range accesses
    // write nothing and read back zero.
    always_comb begin
        ctrl_we   = '0;
        status_we = '0;
        rd_mux    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_idx == i) begin
                ctrl_we[i]   = avs_write && (reg_sel == REG_CTRL);
                status_we[i] = avs_write && (reg_sel == REG_STATUS);
                rd_mux       = rdata_ch[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        hall_channel #(
            .CNT_W        (CNT_W),
            .PERIOD_W     (PERIOD_W),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .hall_in   (hall_in[g]),
            .ctrl_we   (ctrl_we[g]),
            .status_we (status_we[g]),
            .wr_bits   (avs_writedata[2:0]),
            .reg_sel   (reg_sel),
            .rdata     (rdata_ch[g]),
            .irq       (irq_ch[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

    assign irq = |irq_ch;

endmodule

// File: tb/tb_hall_speed_counter_mc.sv
// Directed bench: dut_a uses default widths, dut_b narrow widths for stall,
// overflow and unimplemented-channel cases.
module tb_hall_speed_counter_mc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  a_man, a_gen, a_hall;
    logic [3:0]  a_addr;
    logic        a_rd, a_wr;
    logic [31:0] a_wdata, a_rdata;
    logic        a_irq;
    logic [5:0]  b_man;
    logic [4:0]  b_addr;
    logic        b_rd, b_wr;
    logic [31:0] b_wdata, b_rdata;
    logic        b_irq;
    int          gen_per [4];
    int          gen_cnt [4];
    int          n_cmp = 0;
    int          n_bad = 0;

    assign a_hall = a_man | a_gen;

    always #5 clk = ~clk;

    hall_speed_counter_mc dut_a (
        .clk(clk), .reset_n(reset_n), .hall_in(a_hall), .avs_address(a_addr),
        .avs_read(a_rd), .avs_write(a_wr), .avs_writedata(a_wdata),
        .avs_readdata(a_rdata), .irq(a_irq)
    );

    hall_speed_counter_mc #(
        .NUM_CH(6), .CNT_W(8), .PERIOD_W(8), .DEBOUNCE_CYC(4)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .hall_in(b_man), .avs_address(b_addr),
        .avs_read(b_rd), .avs_write(b_wr), .avs_writedata(b_wdata),
        .avs_readdata(b_rdata), .irq(b_irq)
    );

    // Square-wave source for dut_a: rises every gen_per cycles, high for 20
    initial begin
        a_gen = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (gen_per[i] == 0) begin
                    gen_cnt[i] = 0;
                    a_gen[i]   = 1'b0;
                end else begin
                    a_gen[i]   = (gen_cnt[i] < 20);
                    gen_cnt[i] = (gen_cnt[i] + 1 == gen_per[i]) ? 0 : gen_cnt[i] + 1;
                end
            end
        end
    end

    task automatic bus_wr(input bit sel_b, input int ch, input int r, input logic [31:0] d);
        @(negedge clk);
        if (sel_b) begin
            b_addr = 5'(ch * 4 + r); b_wdata = d; b_wr = 1'b1;
        end else begin
            a_addr = 4'(ch * 4 + r); a_wdata = d; a_wr = 1'b1;
        end
        @(negedge clk);
        a_wr = 1'b0;
        b_wr = 1'b0;
    endtask

    task automatic bus_rd(input bit sel_b, input int ch, input int r, output logic [31:0] d);
        @(negedge clk);
        if (sel_b) begin
            b_addr = 5'(ch * 4 + r); b_rd = 1'b1;
        end else begin
            a_addr = 4'(ch * 4 + r); a_rd = 1'b1;
        end
        @(negedge clk);
        a_rd = 1'b0;
        b_rd = 1'b0;
        d = sel_b ? b_rdata : a_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        n_cmp++; if (a_rdata !== 32'h0 || a_irq !== 1'b0) begin n_bad++;
            $display("FAIL reset_a_outputs: got rdata=%0h irq=%b want 0/0", a_rdata, a_irq); end
        n_cmp++; if (b_rdata !== 32'h0 || b_irq !== 1'b0) begin n_bad++;
            $display("FAIL reset_b_outputs: got rdata=%0h irq=%b want 0/0", b_rdata, b_irq); end
        @(negedge clk);
        reset_n = 1'b1;
        bus_rd(0, 0, 0, v);
        n_cmp++; if (v !== 32'h0) begin n_bad++;
            $display("FAIL reset_count: got %0h want 0", v); end
        bus_rd(0, 1, 2, v);
        n_cmp++; if (v !== 32'h0) begin n_bad++;
            $display("FAIL reset_ctrl: got %0h want 0", v); end
        bus_rd(1, 0, 3, v);
        n_cmp++; if (v !== 32'h0) begin n_bad++;
            $display("FAIL reset_status: got %0h want 0", v); end
    endtask

    task automatic test_debounce();
        logic [31:0] v;
        int first = 0;
        bus_wr(0, 0, 2, 32'h1);
        a_man[0] = 1'b1;
        repeat (15) @(negedge clk);
        a_man[0] = 1'b0;
        repeat (40) @(negedge clk);
        bus_rd(0, 0, 0, v);
        n_cmp++; if (v !== 32'h0) begin n_bad++;
            $display("FAIL deb_short_count: got %0h want 0", v); end
        // Hold a COUNT read open: input rises before P1, edge at P18, COUNT at P19,
        // readdata at P20.
        a_addr = 4'd0;
        a_rd = 1'b1;
        a_man[0] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 16) a_man[0] = 1'b0;
            if (first == 0 && a_rdata == 32'h1) first = k;
        end
        a_rd = 1'b0;
        n_cmp++; if (first !== 20) begin n_bad++;
            $display("FAIL deb_latency: got cycle %0d want 20", first); end
        bus_rd(0, 0, 0, v);
        n_cmp++; if (v !== 32'h1) begin n_bad++;
            $display("FAIL deb_full_count: got %0h want 1", v); end
    endtask

    task automatic test_period();
        logic [31:0] v;
        bus_wr(0, 1, 2, 32'h1);
        gen_per[1] = 1000;
        repeat (100) @(negedge clk);
        bus_rd(0, 1, 3, v);
        n_cmp++; if (v !== 32'h0) begin n_bad++;
            $display("FAIL period_first_status: got %0h want 0", v); end
        bus_rd(0, 1, 1, v);
        n_cmp++; if (v !== 32'h0) begin n_bad++;
            $display("FAIL period_first_value: got %0h want 0", v); end
        repeat (1000) @(negedge clk);
        bus_rd(0, 1, 1, v);
        n_cmp++; if (v !== 32'd1000) begin n_bad++;
            $display("FAIL period_value: got %0d want 1000", v); end
        bus_rd(0, 1, 3, v);
        n_cmp++; if (v !== 32'h4) begin n_bad++;
            $display("FAIL period_valid: got %0h want 4", v); end
        bus_rd(0, 1, 0, v);
        n_cmp++; if (v !== 32'h2) begin n_bad++;
            $display("FAIL period_count: got %0h want 2", v); end
        gen_per[1] = 0;
    endtask

    task automatic test_rw_collision();
        logic [31:0] v;
        @(negedge clk);
        a_addr = 4'(3 * 4 + 2); a_wdata = 32'h1; a_wr = 1'b1; a_rd = 1'b1;
        @(negedge clk);
        a_wr = 1'b0; a_rd = 1'b0;
        n_cmp++; if (a_rdata !== 32'h0) begin n_bad++;
            $display("FAIL rw_pre_write: got %0h want 0", a_rdata); end
        bus_rd(0, 3, 2, v);
        n_cmp++; if (v !== 32'h1) begin n_bad++;
            $display("FAIL rw_post_write: got %0h want 1", v); end
    endtask

    task automatic test_clr_collision();
        logic [31:0] v;
        bus_wr(0, 2, 2, 32'h1);
        for (int n = 0; n < 5; n++) begin
            a_man[2] = 1'b1; repeat (20) @(negedge clk);
            a_man[2] = 1'b0; repeat (20) @(negedge clk);
        end
        bus_rd(0, 2, 0, v);
        n_cmp++; if (v !== 32'h5) begin n_bad++;
            $display("FAIL clr_pre_count: got %0h want 5", v); end
        // Rise before P1, edge consumed at P19; the CLR write lands on P19 too.
        a_man[2] = 1'b1;
        repeat (18) @(negedge clk);
        a_addr = 4'(2 * 4 + 2); a_wdata = 32'h3; a_wr = 1'b1;
        @(negedge clk);
        a_wr = 1'b0;
        @(negedge clk);
        a_man[2] = 1'b0;
        repeat (20) @(negedge clk);
        bus_rd(0, 2, 0, v);
        n_cmp++; if (v !== 32'h0) begin n_bad++;
            $display("FAIL clr_count: got %0h want 0", v); end
        bus_rd(0, 2, 2, v);
        n_cmp++; if (v !== 32'h1) begin n_bad++;
            $display("FAIL clr_ctrl_readback: got %0h want 1", v); end
        a_man[2] = 1'b1; repeat (20) @(negedge clk);
        a_man[2] = 1'b0; repeat (20) @(negedge clk);
        bus_rd(0, 2, 3, v);
        n_cmp++; if (v !== 32'h0) begin n_bad++;
            $display("FAIL clr_next_valid: got %0h want 0", v); end
        bus_rd(0, 2, 0, v);
        n_cmp++; if (v !== 32'h1) begin n_bad++;
            $display("FAIL clr_next_count: got %0h want 1", v); end
    endtask

    task automatic test_stall_irq();
        logic [31:0] v;
        bus_wr(1, 0, 2, 32'h5);
        // Rise before P1, edge consumed at P7, counter saturates at P7+254.
        b_man[0] = 1'b1;
        for (int k = 1; k <= 270; k++) begin
            @(negedge clk);
            if (k == 8) b_man[0] = 1'b0;
            if (k == 260) begin
                n_cmp++; if (b_irq !== 1'b0) begin n_bad++;
                    $display("FAIL stall_early_irq: got %b want 0", b_irq); end
            end
            if (k == 261) begin
                n_cmp++; if (b_irq !== 1'b1) begin n_bad++;
                    $display("FAIL stall_irq: got %b want 1", b_irq); end
            end
        end
        bus_rd(1, 0, 3, v);
        n_cmp++; if (v !== 32'h1) begin n_bad++;
            $display("FAIL stall_status: got %0h want 1", v); end
        b_man[0] = 1'b1; repeat (8) @(negedge clk);
        b_man[0] = 1'b0; repeat (10) @(negedge clk);
        bus_rd(1, 0, 3, v);
        n_cmp++; if (v !== 32'h4) begin n_bad++;
            $display("FAIL stall_edge_clears: got %0h want 4", v); end
        bus_rd(1, 0, 1, v);
        n_cmp++; if (v !== 32'hFF) begin n_bad++;
            $display("FAIL stall_period_sat: got %0h want ff", v); end
        repeat (300) @(negedge clk);
        bus_rd(1, 0, 3, v);
        n_cmp++; if (v !== 32'h5) begin n_bad++;
            $display("FAIL stall_again: got %0h want 5", v); end
        bus_wr(1, 0, 3, 32'h1);
        bus_rd(1, 0, 3, v);
        n_cmp++; if (v !== 32'h4 || b_irq !== 1'b1) begin n_bad++;
            $display("FAIL stall_w1c: got status=%0h irq=%b want 4/1", v, b_irq); end
        bus_wr(1, 0, 3, 32'h4);
        bus_rd(1, 0, 3, v);
        n_cmp++; if (v !== 32'h0 || b_irq !== 1'b0) begin n_bad++;
            $display("FAIL stall_irq_clear: got status=%0h irq=%b want 0/0", v, b_irq); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        bus_wr(1, 1, 2, 32'h1);
        for (int n = 0; n < 256; n++) begin
            b_man[1] = 1'b1; repeat (6) @(negedge clk);
            b_man[1] = 1'b0; repeat (6) @(negedge clk);
        end
        bus_rd(1, 1, 0, v);
        n_cmp++; if (v !== 32'h0) begin n_bad++;
            $display("FAIL ovf_count_wrap: got %0h want 0", v); end
        bus_rd(1, 1, 3, v);
        n_cmp++; if (v !== 32'h6) begin n_bad++;
            $display("FAIL ovf_status: got %0h want 6", v); end
        bus_wr(1, 1, 3, 32'h2);
        bus_rd(1, 1, 3, v);
        n_cmp++; if (v !== 32'h4) begin n_bad++;
            $display("FAIL ovf_w1c: got %0h want 4", v); end
        for (int n = 0; n < 255; n++) begin
            b_man[1] = 1'b1; repeat (6) @(negedge clk);
            b_man[1] = 1'b0; repeat (6) @(negedge clk);
        end
        bus_rd(1, 1, 0, v);
        n_cmp++; if (v !== 32'hFF) begin n_bad++;
            $display("FAIL ovf_count_255: got %0h want ff", v); end
        // Edge consumed at P7; the OVF W1C write lands on the same edge.
        b_man[1] = 1'b1;
        repeat (6) @(negedge clk);
        b_addr = 5'(1 * 4 + 3); b_wdata = 32'h2; b_wr = 1'b1;
        @(negedge clk);
        b_wr = 1'b0;
        repeat (5) @(negedge clk);
        b_man[1] = 1'b0;
        repeat (10) @(negedge clk);
        bus_rd(1, 1, 0, v);
        n_cmp++; if (v !== 32'h0) begin n_bad++;
            $display("FAIL ovf_collide_count: got %0h want 0", v); end
        bus_rd(1, 1, 3, v);
        n_cmp++; if (v !== 32'h6) begin n_bad++;
            $display("FAIL ovf_collide_status: got %0h want 6", v); end
    endtask

    task automatic test_unimplemented();
        logic [31:0] v;
        bus_wr(1, 6, 2, 32'h5);
        bus_rd(1, 6, 2, v);
        n_cmp++; if (v !== 32'h0) begin n_bad++;
            $display("FAIL unimpl_ch6_ctrl: got %0h want 0", v); end
        bus_rd(1, 7, 0, v);
        n_cmp++; if (v !== 32'h0) begin n_bad++;
            $display("FAIL unimpl_ch7_count: got %0h want 0", v); end
        bus_rd(1, 2, 2, v);
        n_cmp++; if (v !== 32'h0) begin n_bad++;
            $display("FAIL unimpl_alias_ch2: got %0h want 0", v); end
    endtask

    task automatic test_isolation_reset();
        logic [31:0] v;
        int exp_per [4];
        exp_per = '{300, 450, 700, 1100};
        for (int c = 0; c < 4; c++) bus_wr(0, c, 2, 32'h5);
        for (int c = 0; c < 4; c++) gen_per[c] = exp_per[c];
        repeat (3000) @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            bus_rd(0, c, 1, v);
            n_cmp++; if (v !== 32'(exp_per[c])) begin n_bad++;
                $display("FAIL iso_period ch%0d: got %0d want %0d", c, v, exp_per[c]); end
        end
        n_cmp++; if (a_irq !== 1'b1) begin n_bad++;
            $display("FAIL iso_irq: got %b want 1", a_irq); end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (a_irq !== 1'b0 || a_rdata !== 32'h0) begin n_bad++;
            $display("FAIL mid_reset_outputs: got irq=%b rdata=%0h want 0/0", a_irq, a_rdata); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                bus_rd(0, c, r, v);
                n_cmp++; if (v !== 32'h0) begin n_bad++;
                    $display("FAIL post_reset ch%0d reg%0d: got %0h want 0", c, r, v); end
            end
        end
        for (int c = 0; c < 4; c++) gen_per[c] = 0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) gen_per[i] = 0;
        reset_n = 1'b0;
        a_man = '0; a_addr = '0; a_rd = 1'b0; a_wr = 1'b0; a_wdata = '0;
        b_man = '0; b_addr = '0; b_rd = 1'b0; b_wr = 1'b0; b_wdata = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_debounce();
        test_period();
        test_rw_collision();
        test_clr_collision();
        test_stall_irq();
        test_overflow();
        test_unimplemented();
        test_isolation_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
